// File: rtl/i2c_target_byte.sv
// I2C target byte engine: answers at a fixed 7-bit address, ACKs every byte
// written by the master and returns tx_dat on reads. SCL is input-only (no
// clock stretching); SDA is open-drain through sda_pad_o/sda_padoen_o.
module i2c_target_byte #(
  parameter logic [6:0] DEV_ADR = 7'h50,
  parameter int         FILT    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  input  logic [7:0] tx_dat,
  output logic [7:0] rx_dat,
  output logic       rx_valid,
  output logic       rd_done,
  output logic       busy
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE
  } state_t;

  state_t        state_r;
  logic          scl_s1_r, scl_s2_r, sda_s1_r, sda_s2_r;
  logic          scl_f_r, sda_f_r, scl_q_r, sda_q_r;
  logic [CW-1:0] scl_cnt_r, sda_cnt_r;
  logic [3:0]    bit_cnt_r;
  logic [6:0]    shift_r;
  logic [7:0]    tx_sh_r;
  logic          rw_r;

  logic       scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] shift_in_s;

  // The open-drain data input of the pad buffer is always low.
  assign sda_pad_o = 1'b0;

  assign scl_rise_s = scl_f_r & ~scl_q_r;
  assign scl_fall_s = ~scl_f_r & scl_q_r;
  assign start_s    = ~sda_f_r & sda_q_r & scl_f_r & scl_q_r;
  assign stop_s     = sda_f_r & ~sda_q_r & scl_f_r & scl_q_r;
  assign shift_in_s = {shift_r, sda_f_r};

  // Two-flop synchronizers, glitch filters and previous-level registers for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1_r  <= 1'b1;
      scl_s2_r  <= 1'b1;
      sda_s1_r  <= 1'b1;
      sda_s2_r  <= 1'b1;
      scl_f_r   <= 1'b1;
      sda_f_r   <= 1'b1;
      scl_q_r   <= 1'b1;
      sda_q_r   <= 1'b1;
      scl_cnt_r <= '0;
      sda_cnt_r <= '0;
    end else begin
      scl_s1_r <= scl_pad_i;
      scl_s2_r <= scl_s1_r;
      sda_s1_r <= sda_pad_i;
      sda_s2_r <= sda_s1_r;
      scl_q_r  <= scl_f_r;
      sda_q_r  <= sda_f_r;
      // a differing sample run must reach FILT before the level flips
      if (scl_s2_r == scl_f_r) begin
        scl_cnt_r <= '0;
      end else if (scl_cnt_r == CNT_MAX) begin
        scl_f_r   <= scl_s2_r;
        scl_cnt_r <= '0;
      end else begin
        scl_cnt_r <= scl_cnt_r + 1'b1;
      end
      if (sda_s2_r == sda_f_r) begin
        sda_cnt_r <= '0;
      end else if (sda_cnt_r == CNT_MAX) begin
        sda_f_r   <= sda_s2_r;
        sda_cnt_r <= '0;
      end else begin
        sda_cnt_r <= sda_cnt_r + 1'b1;
      end
    end
  end

  // Protocol FSM: START/STOP override everything, bits sampled on SCL rise, SDA changed on SCL fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 4'd0;
      shift_r      <= 7'h00;
      tx_sh_r      <= 8'h00;
      rw_r         <= 1'b0;
      sda_padoen_o <= 1'b1;
      rx_dat       <= 8'h00;
      rx_valid     <= 1'b0;
      rd_done      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rd_done  <= 1'b0;
      if (start_s) begin
        state_r      <= ADDR;
        bit_cnt_r    <= 4'd0;
        sda_padoen_o <= 1'b1;
        busy         <= 1'b0;
      end else if (stop_s) begin
        state_r      <= IDLE;
        bit_cnt_r    <= 4'd0;
        sda_padoen_o <= 1'b1;
        busy         <= 1'b0;
      end else begin
        case (state_r)
          ADDR: begin
            if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
              shift_r <= shift_in_s[6:0];
              if (bit_cnt_r == 4'd7) begin
                if (shift_in_s[7:1] == DEV_ADR) begin
                  rw_r      <= shift_in_s[0];
                  busy      <= 1'b1;
                  bit_cnt_r <= 4'd8;
                end else begin
                  state_r   <= IGNORE;
                  bit_cnt_r <= 4'd0;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
              sda_padoen_o <= 1'b0;
              state_r      <= ADR_ACK;
            end
          end
          ADR_ACK: begin
            if (scl_fall_s) begin
              if (rw_r) begin
                tx_sh_r      <= {tx_dat[6:0], 1'b0};
                sda_padoen_o <= tx_dat[7];
                bit_cnt_r    <= 4'd1;
                state_r      <= TX_DATA;
              end else begin
                sda_padoen_o <= 1'b1;
                bit_cnt_r    <= 4'd0;
                state_r      <= RX_DATA;
              end
            end
          end
          RX_DATA: begin
            if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
              shift_r <= shift_in_s[6:0];
              if (bit_cnt_r == 4'd7) begin
                rx_dat    <= shift_in_s;
                rx_valid  <= 1'b1;
                bit_cnt_r <= 4'd8;
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
              sda_padoen_o <= 1'b0;
              state_r      <= RX_ACK;
            end
          end
          RX_ACK: begin
            if (scl_fall_s) begin
              sda_padoen_o <= 1'b1;
              bit_cnt_r    <= 4'd0;
              state_r      <= RX_DATA;
            end
          end
          TX_DATA: begin
            if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_padoen_o <= 1'b1;
                bit_cnt_r    <= 4'd0;
                state_r      <= TX_ACK;
              end else begin
                sda_padoen_o <= tx_sh_r[7];
                tx_sh_r      <= {tx_sh_r[6:0], 1'b0};
                bit_cnt_r    <= bit_cnt_r + 4'd1;
              end
            end
          end
          TX_ACK: begin
            if (scl_rise_s && (bit_cnt_r == 4'd0)) begin
              rd_done <= 1'b1;
              if (sda_f_r) begin
                state_r <= IGNORE;
              end else begin
                bit_cnt_r <= 4'd1;
              end
            end else if (scl_fall_s && (bit_cnt_r == 4'd1)) begin
              tx_sh_r      <= {tx_dat[6:0], 1'b0};
              sda_padoen_o <= tx_dat[7];
              bit_cnt_r    <= 4'd1;
              state_r      <= TX_DATA;
            end
          end
          IDLE, IGNORE: begin
            sda_padoen_o <= 1'b1;
          end
          default: begin
            state_r      <= IDLE;
            sda_padoen_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_target_byte.md
# i2c_target_byte

I2C target (slave) byte engine: responds at a fixed 7-bit device address, accepts master-written bytes and returns a supplied byte on master reads. It is the responder counterpart of the FMC I2C master byte writer, used to emulate an I2C device on the board and to loop back and verify the master path in the same 125-MHz `clk` domain. No clock stretching; SCL is input-only and SDA is open-drain.

## Interface
- `DEV_ADR`, 7'h50, 7-bit address this target answers; every other address, including general call 0x00, is ignored.
- `FILT`, 3, number of consecutive stable clk samples required before a filtered SCL/SDA level changes.
- `clk` input 1: 125-MHz clock.
- `reset` input 1: synchronous, active-high reset.
- `scl_pad_i` input 1: SCL from pin.
- `sda_pad_i` input 1: SDA from pin.
- `sda_pad_o` output 1: constant 0, feeds the tri-state data input.
- `sda_padoen_o` output 1: tri-state enable, active low; 0 drives SDA low, 1 releases it.
- `tx_dat` input 8: byte returned on a read; sampled at the read-address ACK and at each master ACK.
- `rx_dat` output 8: last byte written by the master; held until the next byte.
- `rx_valid` output 1: one-cycle strobe when `rx_dat` updates.
- `rd_done` output 1: one-cycle strobe after the master acknowledges a transmitted byte.
- `busy` output 1: high from an address match until STOP, START or abort.

## Operation
- Input path: 2-FF synchronizer, then a filter. The filtered level takes the new value only after `FILT` equal consecutive samples. Edges are detected on the filtered signals.
- START: filtered SDA falls while filtered SCL is high. STOP: filtered SDA rises while filtered SCL is high. Both are recognised in every state.
- START (including repeated START) goes to ADDR and releases SDA. STOP goes to IDLE, releases SDA and clears `busy`.
- States: IDLE, ADDR, ADR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE.
- Bit timing: SDA is sampled on SCL rise and shifted in MSB first. The target changes SDA only on a detected SCL fall.
- ADDR: shift 8 bits.
  - If `[7:1]` equals `DEV_ADR`: on the next SCL fall drive SDA low (ADR_ACK) and set `busy`.
  - Otherwise go to IGNORE and never drive SDA.
- ADR_ACK: on the SCL fall ending the ACK bit:
  - R/W=0: release SDA and go to RX_DATA.
  - R/W=1: load `tx_dat`, drive bit 7 and go to TX_DATA.
- RX_DATA: after 8 SCL rises, write `rx_dat`, pulse `rx_valid`, drive ACK on the next fall and go to RX_ACK. Every data byte is ACKed. After the ACK bit's SCL fall, release SDA and return to RX_DATA.
- TX_DATA: on each SCL fall drive the next bit; a 1 bit releases SDA, a 0 bit drives it low. After the 8th bit's SCL fall, release SDA and go to TX_ACK.
- TX_ACK: sample SDA on SCL rise.
  - 0 (ACK): pulse `rd_done`, reload `tx_dat` on the next fall and return to TX_DATA.
  - 1 (NACK): pulse `rd_done`, go to IGNORE with SDA released.
- IGNORE: hold SDA released and wait for START or STOP.

## Timing
- Reset values: `sda_padoen_o`=1, `sda_pad_o`=0, `rx_dat`=0, `rx_valid`=0, `rd_done`=0, `busy`=0; state IDLE; filters preset to 1.
- Pad-to-detected-edge latency: 2 sync cycles + `FILT` cycles (5 at default).
- `rx_valid` is asserted the cycle after the 8th data SCL rise is detected.
- `sda_padoen_o` changes 1 cycle after the detected SCL fall.
- Minimum SCL high/low period: `FILT`+4 clk cycles. Glitches shorter than `FILT` cycles are rejected.
- START/STOP mid-byte discards the partial byte: no `rx_valid`, and SDA is released 1 cycle after detection.
- `reset` asserted mid-transfer releases SDA on the next clk edge.

## Test plan
- Write 0xA0 (0x50, W) then 0xA5, STOP -> target ACKs both bytes, one `rx_valid` pulse with `rx_dat`=0xA5, `busy` falls after STOP.
- Address 0x51 write -> SDA never driven low, no strobes, `busy` stays 0.
- Read 0xA1 with `tx_dat`=0x3C, master NACK -> SDA carries 0,0,1,1,1,1,0,0, one `rd_done` pulse, SDA released, state IGNORE until STOP.
- Multi-byte: write 0x11, 0x22, 0x33, then repeated START and read with `tx_dat`=0x5A, ACK then NACK -> three `rx_valid` pulses in order, two bytes 0x5A returned, two `rd_done` pulses.
- STOP after 4 data bits, plus a 2-cycle SCL low glitch during a later byte -> no `rx_valid` for the partial byte, glitch causes no bit shift.
- `reset` pulsed while target drives an ACK -> `sda_padoen_o`=1 next cycle, all outputs at reset values.
